// File: rtl/operand_fetch.sv
// Operand fetch stage: reads two sources from the register file and bypasses a same-cycle write.
// It holds one operand bundle and refreshes held operands from snooped writes while stalled.
module operand_fetch #(
  parameter int Bit_Width        = 16,
  parameter int Number_Registers = 8,
  parameter int Register_Select  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Req_Valid,
  output logic                       Req_Ready,
  input  logic [Register_Select-1:0] Req_Src_A,
  input  logic [Register_Select-1:0] Req_Src_B,
  input  logic [Register_Select-1:0] Req_Dst,
  output logic [Register_Select-1:0] Source_A,
  output logic [Register_Select-1:0] Source_B,
  input  logic [Bit_Width-1:0]       Data_A,
  input  logic [Bit_Width-1:0]       Data_B,
  input  logic                       Write_Enable,
  input  logic [Register_Select-1:0] Write_Destination,
  input  logic [Bit_Width-1:0]       Data_Destination,
  output logic                       Op_Valid,
  input  logic                       Op_Ready,
  output logic [Bit_Width-1:0]       Op_A,
  output logic [Bit_Width-1:0]       Op_B,
  output logic [Register_Select-1:0] Op_Dst,
  output logic [7:0]                 Stall_Count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam int unsigned NREG = Number_Registers;

  state_t                     state_q, state_d;
  logic [Bit_Width-1:0]       op_a_q, op_a_d;
  logic [Bit_Width-1:0]       op_b_q, op_b_d;
  logic [Register_Select-1:0] op_dst_q, op_dst_d;
  logic [Register_Select-1:0] src_a_q, src_a_d;
  logic [Register_Select-1:0] src_b_q, src_b_d;
  logic [7:0]                 stall_q, stall_d;

  logic accept;
  logic stalled;
  logic wr_live;

  assign Source_A    = Req_Src_A;
  assign Source_B    = Req_Src_B;
  assign Op_A        = op_a_q;
  assign Op_B        = op_b_q;
  assign Op_Dst      = op_dst_q;
  assign Stall_Count = stall_q;

  // Writes outside the physical file cannot alias any real source register.
  assign wr_live = Write_Enable && (32'(Write_Destination) < NREG);

  always_comb begin
    state_d   = state_q;
    Req_Ready = 1'b1;
    Op_Valid  = 1'b0;
    case (state_q)
      EMPTY: begin
        Req_Ready = 1'b1;
        if (Req_Valid) state_d = FULL;
      end
      FULL: begin
        Op_Valid  = 1'b1;
        Req_Ready = Op_Ready;
        if (Op_Ready && !Req_Valid) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    accept  = Req_Valid && Req_Ready;
    stalled = (state_q == FULL) && !Op_Ready;
  end

  always_comb begin
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_dst_d = op_dst_q;
    src_a_d  = src_a_q;
    src_b_d  = src_b_q;
    stall_d  = stall_q;
    if (accept) begin
      op_a_d   = (wr_live && Write_Destination == Req_Src_A) ? Data_Destination : Data_A;
      op_b_d   = (wr_live && Write_Destination == Req_Src_B) ? Data_Destination : Data_B;
      op_dst_d = Req_Dst;
      src_a_d  = Req_Src_A;
      src_b_d  = Req_Src_B;
    end else if (stalled) begin
      // Keep a parked bundle coherent with later writes to its sources.
      if (wr_live && Write_Destination == src_a_q) op_a_d = Data_Destination;
      if (wr_live && Write_Destination == src_b_q) op_b_d = Data_Destination;
    end
    if (stalled && stall_q != 8'hFF) stall_d = stall_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_dst_q <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_dst_q <= op_dst_d;
      src_a_q  <= src_a_d;
      src_b_q  <= src_b_d;
      stall_q  <= stall_d;
    end
  end

endmodule
